// File: rtl/dcsformer_host.sv
// Stream initiator for the DCSformer core: holds one job (128 input bytes, 8 weight bytes,
// 8 result words), streams it into the core and captures the result words.
module dcsformer_host (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic        cfg_sel,
  input  logic [6:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err_tmo,
  input  logic [2:0]  res_addr,
  output logic [31:0] res_data,
  output logic        i_valid,
  output logic [7:0]  i_data,
  input  logic        w_ready,
  output logic        w_valid,
  output logic [7:0]  w_data,
  input  logic        o_valid,
  input  logic [31:0] o_data
);
  localparam int N_IN  = 128;
  localparam int N_W   = 8;
  localparam int N_OUT = 8;
  localparam int TMO   = 255;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEND_I  = 3'd1;
  localparam logic [2:0] S_WAIT_WR = 3'd2;
  localparam logic [2:0] S_SEND_W  = 3'd3;
  localparam logic [2:0] S_WAIT_O  = 3'd4;
  localparam logic [2:0] S_RECV    = 3'd5;

  logic [7:0]  inbuf  [N_IN];
  logic [7:0]  wbuf   [N_W];
  logic [31:0] resbuf [N_OUT];

  logic [2:0] state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [7:0] tmo_q, tmo_d;
  logic [2:0] k_q, k_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic       i_valid_q, i_valid_d, w_valid_q, w_valid_d;
  logic [7:0] i_data_q, i_data_d, w_data_q, w_data_d;
  logic       res_we, tmo_hit;

  // tmo_q counts completed wait cycles; the 255th idle wait cycle ends the job
  assign tmo_hit = (tmo_q == 8'(TMO - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    k_d       = k_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    i_valid_d = 1'b0;
    i_data_d  = 8'd0;
    w_valid_d = 1'b0;
    w_data_d  = 8'd0;
    res_we    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_SEND_I;
        cnt_d     = 7'd0;
        err_d     = 1'b0;
        busy_d    = 1'b1;
        i_valid_d = 1'b1;
        i_data_d  = inbuf[0];
      end
      // cnt_q is the index of the byte currently on i_data
      S_SEND_I: if (cnt_q == 7'(N_IN - 1)) begin
        state_d = S_WAIT_WR;
        tmo_d   = 8'd0;
      end else begin
        cnt_d     = cnt_q + 7'd1;
        i_valid_d = 1'b1;
        i_data_d  = inbuf[cnt_q + 7'd1];
      end
      S_WAIT_WR: if (w_ready) begin
        state_d   = S_SEND_W;
        cnt_d     = 7'd0;
        w_valid_d = 1'b1;
        w_data_d  = wbuf[0];
      end else if (tmo_hit) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        busy_d  = 1'b0;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
      S_SEND_W: if (cnt_q == 7'(N_W - 1)) begin
        state_d = S_WAIT_O;
        tmo_d   = 8'd0;
        k_d     = 3'd0;
      end else begin
        cnt_d     = cnt_q + 7'd1;
        w_valid_d = 1'b1;
        w_data_d  = wbuf[cnt_q[2:0] + 3'd1];
      end
      S_WAIT_O, S_RECV: if (o_valid) begin
        res_we = 1'b1;
        tmo_d  = 8'd0;
        k_d    = k_q + 3'd1;
        if (k_q == 3'(N_OUT - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_RECV;
        end
      end else if (tmo_hit) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        busy_d  = 1'b0;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 7'd0;
      tmo_q     <= 8'd0;
      k_q       <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      i_valid_q <= 1'b0;
      i_data_q  <= 8'd0;
      w_valid_q <= 1'b0;
      w_data_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      i_valid_q <= i_valid_d;
      i_data_q  <= i_data_d;
      w_valid_q <= w_valid_d;
      w_data_q  <= w_data_d;
    end
  end

  // Buffers carry no reset; software reloads them per job
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == S_IDLE) begin
      if (cfg_sel) wbuf[cfg_addr[2:0]] <= cfg_wdata;
      else         inbuf[cfg_addr]     <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (res_we) resbuf[k_q] <= o_data;
  end

  assign res_data = resbuf[res_addr];
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_tmo  = err_q;
  assign i_valid  = i_valid_q;
  assign i_data   = i_data_q;
  assign w_valid  = w_valid_q;
  assign w_data   = w_data_q;
endmodule

// File: tb/tb_dcsformer_host.sv
// Bench for dcsformer_host: a scripted core responder plus a job-level reference model
// (expected byte streams, latencies and result words derived from the job rules).
module tb_dcsformer_host;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [6:0]  cfg_addr = 7'd0;
  logic [7:0]  cfg_wdata = 8'd0;
  logic        start = 1'b0;
  logic        busy, done, err_tmo;
  logic [2:0]  res_addr = 3'd0;
  logic [31:0] res_data;
  logic        i_valid, w_valid;
  logic [7:0]  i_data, w_data;
  logic        w_ready = 1'b0, o_valid = 1'b0;
  logic [31:0] o_data = 32'd0;

  dcsformer_host dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .busy(busy), .done(done), .err_tmo(err_tmo),
    .res_addr(res_addr), .res_data(res_data), .i_valid(i_valid), .i_data(i_data),
    .w_ready(w_ready), .w_valid(w_valid), .w_data(w_data), .o_valid(o_valid), .o_data(o_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [7:0]  m_in  [128];
  logic [7:0]  m_w   [8];
  logic [31:0] m_res [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cfg_wr(input logic sel, input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // wr_dly < 0 withholds w_ready; fewer than 8 words ends in a timeout; abort_w > 0 resets
  // the host on that weight byte. spur adds start/cfg/w_ready/o_valid noise while busy.
  task automatic run_job(input int start_len, input int wr_dly, input int o_dly, input int gap_mode,
                         input int n_words, input int fixed, input int spur, input int abort_w);
    int cyc = 0, i_cnt = 0, i_first = -1, i_last = -1, w_cnt = 0, w_first = -1, w_last = -1;
    int done_cnt = 0, done_cyc = -1, err_cyc = -1, wr_cyc = -1, o_start = -1, busy_on = -1;
    int zero_bad = 0, i_bad = 0, w_bad = 0, oi = 0, t = 0, fin, last_ref;
    logic busy_at_done = 1'b1, err_at1 = 1'b1;
    int offs[$];
    logic [31:0] words[$];
    for (int j = 0; j < n_words; j++) begin
      words.push_back(fixed != 0 ? 32'(j) * 32'h01010101 : 32'($urandom));
      offs.push_back(t);
      t += 1 + ((gap_mode == 1 && j == 3) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0);
    end
    forever begin
      @(negedge clk);
      if (i_valid) begin
        if (i_cnt < 128 && i_data !== m_in[i_cnt]) i_bad++;
        if (i_first < 0) i_first = cyc;
        i_last = cyc; i_cnt++;
      end else if (i_data !== 8'd0) zero_bad++;
      if (w_valid) begin
        if (w_cnt < 8 && w_data !== m_w[w_cnt]) w_bad++;
        if (w_first < 0) w_first = cyc;
        w_last = cyc; w_cnt++;
      end else if (w_data !== 8'd0) zero_bad++;
      if (busy === 1'b1 && busy_on < 0) busy_on = cyc;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
      end
      if (cyc == 1) err_at1 = err_tmo;
      if (cyc >= 1 && err_tmo === 1'b1 && err_cyc < 0) err_cyc = cyc;
      if (abort_w > 0 && w_cnt == abort_w) begin
        rst_n = 1'b0;
        #1;
        chk("abort_w_valid", 32'(w_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_i_valid", 32'(i_valid), 32'd0);
        start = 1'b0; w_ready = 1'b0; o_valid = 1'b0; cfg_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      fin = (done_cyc >= 0) ? done_cyc : err_cyc;
      if (fin >= 0 && cyc >= fin + 4 && oi >= n_words) break;
      if (cyc > 3000) begin
        chk("job_budget", 32'(cyc), 32'd3000);
        break;
      end
      start = (cyc < start_len);
      w_ready = 1'b0; o_valid = 1'b0; o_data = $urandom; cfg_we = 1'b0;
      if (spur != 0 && i_valid) begin
        if (i_cnt == 50) start = 1'b1;
        if (i_cnt == 60) begin
          cfg_we = 1'b1; cfg_sel = 1'($urandom); cfg_addr = 7'($urandom);
          cfg_wdata = cfg_sel ? ~m_w[cfg_addr[2:0]] : ~m_in[cfg_addr];
        end
        if (i_cnt == 70) o_valid = 1'b1;
        if ((i_cnt >= 80 && i_cnt <= 84) || i_cnt == 128) w_ready = 1'b1;
      end
      if (i_cnt == 128 && !i_valid && wr_dly >= 0 && wr_cyc < 0 && cyc == i_last + 1 + wr_dly) begin
        w_ready = 1'b1; wr_cyc = cyc;
      end
      if (w_cnt == 8 && !w_valid && o_start < 0) o_start = cyc + o_dly;
      if (o_start >= 0 && oi < n_words && cyc == o_start + offs[oi]) begin
        o_valid = 1'b1; o_data = words[oi]; oi++;
      end
      cyc++;
    end
    start = 1'b0; w_ready = 1'b0; o_valid = 1'b0; cfg_we = 1'b0;
    chk("i_first", 32'(i_first), 32'd1);
    chk("i_count", 32'(i_cnt), 32'd128);
    chk("i_contig", 32'(i_last - i_first + 1), 32'd128);
    chk("i_bytes", 32'(i_bad), 32'd0);
    chk("busy_on", 32'(busy_on), 32'd1);
    chk("err_cleared", 32'(err_at1), 32'd0);
    if (wr_dly >= 0 && n_words >= 8) begin
      chk("w_count", 32'(w_cnt), 32'd8);
      chk("w_latency", 32'(w_first), 32'(wr_cyc + 1));
      chk("w_bytes", 32'(w_bad), 32'd0);
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("done_cycle", 32'(done_cyc), 32'(o_start + offs[7] + 1));
      chk("busy_at_done", 32'(busy_at_done), 32'd0);
      chk("err_none", 32'(err_tmo), 32'd0);
      for (int k = 0; k < 8; k++) m_res[k] = words[k];
    end else begin
      last_ref = (wr_dly < 0) ? i_last : (n_words > 0) ? o_start + offs[n_words - 1] : w_last;
      chk("tmo_cycle", 32'(err_cyc - last_ref), 32'd256);
      chk("tmo_done", 32'(done_cnt), 32'd0);
      chk("tmo_err", 32'(err_tmo), 32'd1);
      if (wr_dly < 0) chk("tmo_no_w", 32'(w_cnt), 32'd0);
      for (int k = 0; k < n_words; k++) m_res[k] = words[k];
    end
    chk("busy_end", 32'(busy), 32'd0);
    chk("zero_data", 32'(zero_bad), 32'd0);
    for (int k = 0; k < 8; k++) begin
      res_addr = 3'(k);
      #1;
      chk($sformatf("res%0d", k), res_data, m_res[k]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r, wr, nw;
    logic [6:0] a;
    logic [7:0] d;
    for (int k = 0; k < 8; k++) m_res[k] = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_tmo), 32'd0);
    chk("rst_i_valid", 32'(i_valid), 32'd0);
    chk("rst_w_valid", 32'(w_valid), 32'd0);
    chk("rst_i_data", 32'(i_data), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);
    rst_n = 1'b1;
    for (int n = 0; n < 128; n++) begin m_in[n] = 8'(n); cfg_wr(1'b0, 7'(n), 8'(n)); end
    for (int k = 0; k < 8; k++) begin m_w[k] = 8'(k + 1); cfg_wr(1'b1, 7'(k), 8'(k + 1)); end
    run_job(3, 5, 3, 0, 8, 1, 1, 0);      // reference vector, start held 3 cycles
    run_job(1, 0, 0, 1, 8, 0, 0, 0);      // 4 words, 2-cycle gap, 4 words
    run_job(1, -1, 0, 0, 0, 0, 1, 0);     // w_ready withheld
    run_job(1, 254, 254, 0, 10, 0, 0, 0); // last-chance waits, extra words
    run_job(1, 2, 1, 2, 4, 0, 0, 0);      // result stream stalls after 4 words
    run_job(1, 3, 2, 0, 8, 0, 0, 3);      // reset during third weight byte
    run_job(1, 3, 2, 0, 8, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin m_w[k] = 8'($urandom); cfg_wr(1'b1, 7'(k), m_w[k]); end
    run_job(1, 7, 5, 2, 8, 0, 1, 0);
    run_job(1, 1, 1, 0, 8, 0, 1, 0);
    repeat (6) begin
      repeat (4) begin
        a = 7'($urandom); d = 8'($urandom);
        m_in[a] = d; cfg_wr(1'b0, a, d);
      end
      r  = int'($urandom_range(0, 5));
      wr = (r == 0) ? -1 : int'($urandom_range(0, 40));
      nw = (r == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(8, 10));
      run_job(int'($urandom_range(1, 3)), wr, int'($urandom_range(0, 40)), 2,
              (wr < 0) ? 0 : nw, 0, int'($urandom_range(0, 1)), 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
